// File: rtl/mod_icache_fill.sv
// Direct-mapped read-only instruction cache: 64-byte lines, 64-bit fetch words,
// one outstanding line fill towards the arbiter, whole-cache flush.
module mod_icache_fill #(
  parameter int ADDR_WIDTH = 64,
  parameter int INDEX_BITS = 6,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_rvalid,
  output logic [0:63]           fetch_rdata,
  input  logic                  flush,
  output logic                  reqcyc,
  output logic [ADDR_WIDTH-1:0] req,
  output logic [TAG_WIDTH-1:0]  reqtag,
  input  logic                  reqack,
  input  logic                  respcyc,
  input  logic [0:DATA_WIDTH-1] resp,
  input  logic [TAG_WIDTH-1:0]  resptag
);
  localparam int OFF_BITS = 6;
  localparam int NSETS    = 1 << INDEX_BITS;
  localparam int LINE_W   = ADDR_WIDTH - OFF_BITS;
  localparam int LTAG_W   = LINE_W - INDEX_BITS;
  localparam logic [TAG_WIDTH-1:0] READ_TAG = {1'b1, {(TAG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MISS_REQ, S_MISS_WAIT, S_RESPOND} state_t;

  state_t                  state_q;
  logic [NSETS-1:0]        valid_q;
  logic [LTAG_W-1:0]       tag_q  [NSETS];
  logic [0:DATA_WIDTH-1]   data_q [NSETS];
  logic [LINE_W-1:0]       line_q;
  logic [2:0]              word_q;
  logic                    flush_pend_q;
  logic                    rvalid_q;
  logic [0:63]             rdata_q;
  logic                    reqcyc_q;
  logic [ADDR_WIDTH-1:0]   req_q;
  logic [TAG_WIDTH-1:0]    reqtag_q;

  logic [INDEX_BITS-1:0]   in_index;
  logic [LTAG_W-1:0]       in_tag;
  logic [8:0]              hit_base;
  logic [8:0]              fill_base;
  logic [INDEX_BITS-1:0]   miss_index;
  logic                    hit;
  logic                    flush_any;
  logic                    accept;
  logic                    fill_now;
  logic                    unused_bits;

  assign in_index   = fetch_addr[OFF_BITS +: INDEX_BITS];
  assign in_tag     = fetch_addr[ADDR_WIDTH-1 -: LTAG_W];
  assign hit_base   = {fetch_addr[5:3], 6'b0};
  assign fill_base  = {word_q, 6'b0};
  assign miss_index = line_q[INDEX_BITS-1:0];
  assign hit        = valid_q[in_index] && (tag_q[in_index] == in_tag);
  assign flush_any  = flush || flush_pend_q;
  assign fetch_ready = !reset && (state_q == S_IDLE) && !flush_any;
  assign accept     = fetch_valid && fetch_ready;
  // A response arriving together with the ack is taken straight from MISS_REQ.
  assign fill_now   = respcyc && ((state_q == S_MISS_WAIT) ||
                                  ((state_q == S_MISS_REQ) && reqack));
  assign unused_bits = ^{resptag, fetch_addr[2:0]};

  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rdata_q;
  assign reqcyc       = reqcyc_q;
  assign req          = req_q;
  assign reqtag       = reqtag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      line_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      reqtag_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (state_q != S_IDLE && flush) flush_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (flush_any) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (accept) begin
            line_q <= fetch_addr[ADDR_WIDTH-1:OFF_BITS];
            word_q <= fetch_addr[5:3];
            if (hit) begin
              rvalid_q <= 1'b1;
              rdata_q  <= data_q[in_index][hit_base +: 64];
            end else begin
              state_q  <= S_MISS_REQ;
              reqcyc_q <= 1'b1;
              req_q    <= {fetch_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
              reqtag_q <= READ_TAG;
            end
          end
        end
        S_MISS_REQ: begin
          if (reqack) begin
            reqcyc_q <= 1'b0;
            state_q  <= respcyc ? S_RESPOND : S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (respcyc) state_q <= S_RESPOND;
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
      if (fill_now) begin
        valid_q[miss_index] <= 1'b1;
        rvalid_q            <= 1'b1;
        rdata_q             <= resp[fill_base +: 64];
      end
    end
  end

  // Tag and line storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_now) begin
      tag_q[miss_index]  <= line_q[LINE_W-1 -: LTAG_W];
      data_q[miss_index] <= resp;
    end
  end
endmodule
